// File: rtl/byte_pair_arbiter.sv
// byte_pair_arbiter: round-robin grant between two byte requesters, assembles
// {high, low} into a 16-bit word and presents it on a valid/ready handshake.
// A stall counter aborts a transaction whose granted requester stops sending.
// Optional build macro PARITY_CHECK_EN adds par0/par1 inputs (odd parity over
// {parN, dataN}) and a parity_err output that is held alongside word_valid.
module byte_pair_arbiter #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [7:0]  data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [7:0]  data1,
  output logic        ack1,
  output logic        sel,
  output logic [15:0] word,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        busy,
  output logic        abort
`ifdef PARITY_CHECK_EN
  ,
  input  logic        par0,
  input  logic        par1,
  output logic        parity_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_OUT} state_t;

  state_t             state_q, state_d;
  logic               sel_q, sel_d;
  logic [15:0]        word_q, word_d;
  logic               word_valid_q, word_valid_d;
  logic               abort_q, abort_d;
  logic               busy_q, busy_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               timeout;
  logic               beat_phase;
  logic               accept;
  logic [7:0]         byte_in;

  // Byte handshake: only the granted requester is acked, and only in LOW/HIGH.
  assign beat_phase = (state_q == S_LOW) || (state_q == S_HIGH);
  assign ack0       = !rst && beat_phase && !sel_q && req0;
  assign ack1       = !rst && beat_phase &&  sel_q && req1;
  assign accept     = ack0 || ack1;
  assign byte_in    = sel_q ? data1 : data0;

  // Stall detection: the stall about to be counted reaches the limit.
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign timeout = (WAIT_LIMIT != 0) && (cnt_inc == CNT_W'(WAIT_LIMIT));

  // Next-state and next-output computation.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    abort_d      = 1'b0;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          sel_d   = (req0 && req1) ? ~last_grant_q : req1;
          state_d = S_LOW;
          cnt_d   = '0;
        end
      end
      S_LOW, S_HIGH: begin
        if (accept) begin
          cnt_d = '0;
          if (state_q == S_LOW) begin
            word_d[7:0] = byte_in;
            state_d     = S_HIGH;
          end else begin
            word_d[15:8] = byte_in;
            word_valid_d = 1'b1;
            state_d      = S_OUT;
          end
        end else if (timeout) begin
          // Drop the transaction and hand priority to the other requester.
          state_d      = S_IDLE;
          abort_d      = 1'b1;
          last_grant_d = sel_q;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_OUT: begin
        if (word_ready) begin
          word_valid_d = 1'b0;
          last_grant_d = sel_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      word_q       <= 16'h0000;
      word_valid_q <= 1'b0;
      abort_q      <= 1'b0;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      abort_q      <= abort_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign sel        = sel_q;
  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign busy       = busy_q;
  assign abort      = abort_q;

`ifdef PARITY_CHECK_EN
  logic low_perr_q, low_perr_d;
  logic parity_err_q, parity_err_d;
  logic par_in;
  logic beat_bad;

  assign par_in   = sel_q ? par1 : par0;
  assign beat_bad = ~(^{par_in, byte_in});

  // Remember a bad low beat; publish the combined result with the word.
  always_comb begin
    low_perr_d   = low_perr_q;
    parity_err_d = parity_err_q;
    if (accept && (state_q == S_LOW)) begin
      low_perr_d = beat_bad;
    end
    if (accept && (state_q == S_HIGH)) begin
      parity_err_d = low_perr_q | beat_bad;
    end
    if ((state_q == S_OUT) && word_ready) begin
      parity_err_d = 1'b0;
    end
  end

  // Parity flags with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      low_perr_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      low_perr_q   <= low_perr_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_byte_pair_arbiter.sv
// Directed bench for byte_pair_arbiter: expected words are queued as the high
// byte is driven and compared whenever the DUT completes a handshake.
module tb_byte_pair_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [7:0]  data0, data1;
  logic        ack0, ack1;
  logic        sel;
  logic [15:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        busy;
  logic        abort;
`ifdef PARITY_CHECK_EN
  logic        par0, par1, parity_err;
  logic        bad0, bad1;
  assign par0 = ~(^data0) ^ bad0;
  assign par1 = ~(^data1) ^ bad1;
`endif

  int          tests;
  int          fails;
  int          pushes;
  int          pops;
  logic [15:0] sb[$];

  byte_pair_arbiter #(.WAIT_LIMIT(3), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .data0      (data0),
    .ack0       (ack0),
    .req1       (req1),
    .data1      (data1),
    .ack1       (ack1),
    .sel        (sel),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .abort      (abort)
`ifdef PARITY_CHECK_EN
    ,
    .par0       (par0),
    .par1       (par1),
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    sb.push_back(w);
    pushes++;
  endtask

  // Scoreboard: every completed handshake must match the oldest queued word.
  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_underflow observed=%h expected=none", word);
      end else begin
        pops++;
        chk16("sb_word", word, sb.pop_front());
      end
    end
  end

  initial begin
    logic       g;
    logic [7:0] lo0, hi0, lo1, hi1;
    tests = 0; fails = 0; pushes = 0; pops = 0;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    word_ready = 1'b0;
`ifdef PARITY_CHECK_EN
    bad0 = 1'b0; bad1 = 1'b0;
`endif
    next_cyc();
    next_cyc();
    rst = 1'b0;
    settle();
    chk1("rst_sel", sel, 1'b0);
    chk16("rst_word", word, 16'h0000);
    chk1("rst_valid", word_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_abort", abort, 1'b0);

    // Single requester 0: 0x34 then 0x12.
    req0 = 1'b1; data0 = 8'h34; settle();
    chk1("t1_c0_ack0", ack0, 1'b0);
    next_cyc(); settle();
    chk1("t1_c1_sel", sel, 1'b0);
    chk1("t1_c1_ack0", ack0, 1'b1);
    chk1("t1_c1_ack1", ack1, 1'b0);
    chk1("t1_c1_busy", busy, 1'b1);
    next_cyc(); data0 = 8'h12; push(16'h1234); settle();
    chk1("t1_c2_ack0", ack0, 1'b1);
    next_cyc(); req0 = 1'b0; word_ready = 1'b1; settle();
    chk1("t1_c3_valid", word_valid, 1'b1);
    chk16("t1_c3_word", word, 16'h1234);
    chk1("t1_c3_ack0", ack0, 1'b0);
    next_cyc(); settle();
    chk1("t1_c4_busy", busy, 1'b0);
    chk1("t1_c4_valid", word_valid, 1'b0);
    next_cyc(); settle();
    chk1("t1_c5_busy", busy, 1'b0);

    // Both requesters held: grants alternate, starting with 1 (last grant was 0).
    req0 = 1'b1; req1 = 1'b1;
    for (int t = 0; t < 4; t++) begin
      g   = (t % 2 == 0);
      lo0 = 8'(8'h10 + t); hi0 = 8'(8'h20 + t);
      lo1 = 8'(8'h30 + t); hi1 = 8'(8'h40 + t);
      next_cyc(); data0 = lo0; data1 = lo1; settle();
      chk1("t2_sel", sel, g);
      chk1("t2_lo_ack0", ack0, ~g);
      chk1("t2_lo_ack1", ack1, g);
      next_cyc(); data0 = hi0; data1 = hi1;
      push(g ? {hi1, lo1} : {hi0, lo0}); settle();
      chk1("t2_hi_ack0", ack0, ~g);
      chk1("t2_hi_ack1", ack1, g);
      next_cyc(); settle();
      chk1("t2_out_valid", word_valid, 1'b1);
      chk1("t2_out_ack0", ack0, 1'b0);
      chk1("t2_out_ack1", ack1, 1'b0);
      next_cyc();
      if (t == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      settle();
      chk1("t2_idle_busy", busy, 1'b0);
    end

    // Backpressure: word_ready low for 5 cycles in OUT.
    req1 = 1'b1; word_ready = 1'b0;
    next_cyc(); data1 = 8'hC3; settle();
    chk1("t3_sel", sel, 1'b1);
    chk1("t3_lo_ack1", ack1, 1'b1);
    next_cyc(); data1 = 8'h3C; push(16'h3CC3); settle();
    chk1("t3_hi_ack1", ack1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      next_cyc(); settle();
      chk1("t3_hold_valid", word_valid, 1'b1);
      chk16("t3_hold_word", word, 16'h3CC3);
      chk1("t3_hold_ack1", ack1, 1'b0);
    end
    next_cyc(); word_ready = 1'b1; req1 = 1'b0; settle();
    chk1("t3_ready_valid", word_valid, 1'b1);
    next_cyc(); settle();
    chk1("t3_done_valid", word_valid, 1'b0);
    chk1("t3_done_busy", busy, 1'b0);

    // Timeout: requester 1 stalls after its low byte.
    req1 = 1'b1;
    next_cyc(); data1 = 8'h77; settle();
    chk1("t4_lo_ack1", ack1, 1'b1);
    next_cyc(); req1 = 1'b0; settle();
    chk1("t4_s1_abort", abort, 1'b0);
    next_cyc(); settle();
    chk1("t4_s2_abort", abort, 1'b0);
    chk1("t4_s2_busy", busy, 1'b1);
    next_cyc(); settle();
    chk1("t4_s3_abort", abort, 1'b0);
    chk1("t4_s3_busy", busy, 1'b1);
    next_cyc(); settle();
    chk1("t4_abort", abort, 1'b1);
    chk1("t4_abort_busy", busy, 1'b0);
    chk1("t4_abort_valid", word_valid, 1'b0);
    chk16("t4_abort_word", word, 16'h3C77);
    next_cyc(); req0 = 1'b1; req1 = 1'b1; settle();
    chk1("t4_abort_pulse", abort, 1'b0);
    next_cyc(); data0 = 8'h01; settle();
    chk1("t4_tie_sel", sel, 1'b0);
    chk1("t4_tie_ack0", ack0, 1'b1);
    chk1("t4_tie_ack1", ack1, 1'b0);
    next_cyc(); data0 = 8'h02; push(16'h0201); settle();
    chk1("t4_hi_ack0", ack0, 1'b1);
    next_cyc(); req0 = 1'b0; req1 = 1'b0; settle();
    chk1("t4_out_valid", word_valid, 1'b1);
    chk16("t4_out_word", word, 16'h0201);
    next_cyc();

    // Reset while in HIGH, then a fresh transaction.
    req1 = 1'b1;
    next_cyc(); data1 = 8'h99; settle();
    chk1("t5_sel", sel, 1'b1);
    chk1("t5_lo_ack1", ack1, 1'b1);
    next_cyc(); rst = 1'b1; data1 = 8'h88; settle();
    chk1("t5_rst_ack1", ack1, 1'b0);
    next_cyc(); rst = 1'b0; req1 = 1'b0; settle();
    chk1("t5_busy", busy, 1'b0);
    chk16("t5_word", word, 16'h0000);
    chk1("t5_valid", word_valid, 1'b0);
    chk1("t5_sel0", sel, 1'b0);
    req1 = 1'b1;
    next_cyc(); data1 = 8'h5E; settle();
    chk1("t5_new_sel", sel, 1'b1);
    chk1("t5_new_ack1", ack1, 1'b1);
    next_cyc(); data1 = 8'hE5; push(16'hE55E); settle();
    chk1("t5_new_hi_ack1", ack1, 1'b1);
    next_cyc(); req1 = 1'b0; word_ready = 1'b1; settle();
    chk1("t5_new_valid", word_valid, 1'b1);
    chk16("t5_new_word", word, 16'hE55E);
    next_cyc(); settle();
    chk1("t5_new_busy", busy, 1'b0);

`ifdef PARITY_CHECK_EN
    // Bad-parity high byte, then a clean transaction.
    req0 = 1'b1;
    next_cyc(); data0 = 8'h0F; settle();
    next_cyc(); data0 = 8'hF0; bad0 = 1'b1; push(16'hF00F); settle();
    next_cyc(); bad0 = 1'b0; req0 = 1'b0; settle();
    chk1("t6_perr", parity_err, 1'b1);
    chk1("t6_valid", word_valid, 1'b1);
    next_cyc(); settle();
    chk1("t6_perr_clr", parity_err, 1'b0);
    req0 = 1'b1;
    next_cyc(); data0 = 8'h55; settle();
    next_cyc(); data0 = 8'hAA; push(16'hAA55); settle();
    next_cyc(); req0 = 1'b0; settle();
    chk1("t6_good_perr", parity_err, 1'b0);
    chk1("t6_good_valid", word_valid, 1'b1);
    next_cyc(); settle();
`endif

    next_cyc(); settle();
    chk16("sb_empty", 16'(sb.size()), 16'h0000);
    chk16("sb_count", 16'(pops), 16'(pushes));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
